// File: rtl/muxn_and_reg.sv
// Registered N-way mux followed by a bitwise AND gate. The result is held in a
// two-entry main/skid buffer so the upstream ready never depends on the downstream ready.
module muxn_and_reg #(
    parameter  int WIDTH  = 1,
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_IN*WIDTH-1:0] i_i,
    input  logic [SEL_W-1:0]        s_i,
    input  logic [WIDTH-1:0]        b_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [WIDTH-1:0]        y_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    logic [WIDTH-1:0] res;
    logic             accept;
    logic             main_free;

    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] main_dat_q, main_dat_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;

    // Select codes with no matching channel leave res at zero.
    always_comb begin
        res = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (s_i == SEL_W'(k)) begin
                res = i_i[k*WIDTH +: WIDTH] & b_i;
            end
        end
    end

    assign ready_o   = !rst_i && !skid_vld_q;
    assign accept    = valid_i && ready_o;
    assign main_free = !main_vld_q || ready_i;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (main_free) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                skid_vld_d = accept;
                if (accept) begin
                    skid_dat_d = res;
                end
            end else if (accept) begin
                main_vld_d = 1'b1;
                main_dat_d = res;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_dat_d = res;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign y_o     = main_dat_q;
    assign valid_o = main_vld_q;

endmodule

// File: tb/tb_muxn_and_reg.sv
// Randomized scoreboard bench for muxn_and_reg: an 8-bit/4-way instance and a
// 4-bit/3-way instance exercising out-of-range selects.
module tb_muxn_and_reg;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] i_i = '0;
    logic [1:0]  s_i = '0;
    logic [7:0]  b_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  y_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    logic [11:0] i3 = '0;
    logic [1:0]  s3 = '0;
    logic [3:0]  b3 = '0;
    logic        v3 = 1'b0;
    logic        rdy3_o;
    logic [3:0]  y3;
    logic        vo3;
    logic        ri3 = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [3:0] q3[$];

    always #5 clk = ~clk;

    muxn_and_reg #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .i_i(i_i), .s_i(s_i), .b_i(b_i),
        .valid_i(valid_i), .ready_o(ready_o), .y_o(y_o), .valid_o(valid_o),
        .ready_i(ready_i)
    );

    muxn_and_reg #(.WIDTH(4), .NUM_IN(3)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .i_i(i3), .s_i(s3), .b_i(b3),
        .valid_i(v3), .ready_o(rdy3_o), .y_o(y3), .valid_o(vo3),
        .ready_i(ri3)
    );

    // Reference: pick channel s by shifting, mask to w bits, AND with gate; invalid select gives 0.
    function automatic logic [31:0] model(logic [31:0] ins, int s, logic [31:0] g, int n, int w);
        if (s >= n) return 0;
        return ((ins >> (s * w)) & ((32'd1 << w) - 1)) & g;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Scoreboard push: inputs are stable from posedge+1, so sample them just after negedge.
    always @(negedge clk) begin
        #1;
        if (rst_i) begin
            q.delete();
            q3.delete();
        end else begin
            if (valid_i && ready_o) q.push_back(8'(model(i_i, int'(s_i), 32'(b_i), 4, 8)));
            if (v3 && rdy3_o) q3.push_back(4'(model(32'(i3), int'(s3), 32'(b3), 3, 4)));
        end
    end

    // Monitor: the queue depth is the number of results the DUT should be holding.
    bit         stall_q = 1'b0;
    logic [7:0] stall_y = '0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_i) begin
            chk(ready_o == 1'b0, "ready_o_in_reset", 32'(ready_o), 0);
            stall_q = 1'b0;
        end else begin
            chk(ready_o == (q.size() < 2), "ready_o", 32'(ready_o), 32'(q.size() < 2));
            chk(valid_o == (q.size() > 0), "valid_o", 32'(valid_o), 32'(q.size() > 0));
            if (stall_q) chk(y_o == stall_y, "stall_y_o", 32'(y_o), 32'(stall_y));
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_output", 32'(y_o), 0);
                end else begin
                    e = q.pop_front();
                    chk(y_o == e, "y_o", 32'(y_o), 32'(e));
                end
            end
            stall_q = valid_o && !ready_i;
            stall_y = y_o;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst_i) begin
            chk(vo3 == (q3.size() > 0), "valid_o3", 32'(vo3), 32'(q3.size() > 0));
            if (vo3 && ri3) begin
                if (q3.size() == 0) begin
                    chk(1'b0, "unexpected_output3", 32'(y3), 0);
                end else begin
                    e = q3.pop_front();
                    chk(y3 == e, "y_o3", 32'(y3), 32'(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand3();
        v3  = 1'($urandom);
        s3  = 2'($urandom);
        b3  = 4'($urandom);
        i3  = 12'($urandom);
        ri3 = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk(y_o == 8'h00, "reset_y_o", 32'(y_o), 0);
        chk(valid_o == 1'b0, "reset_valid_o", 32'(valid_o), 0);
        chk(ready_o == 1'b0, "reset_ready_o", 32'(ready_o), 0);
        rst_i = 1'b0;
        #1;
        chk(ready_o == 1'b1, "ready_after_release", 32'(ready_o), 1);

        // Basic select/gate, plus out-of-range select on the 3-way instance.
        i_i = {8'hF0, 8'h3C, 8'hAA, 8'h55};
        s_i = 2'd1; b_i = 8'h0F; valid_i = 1'b1; ready_i = 1'b1;
        i3 = 12'hFFF; s3 = 2'd3; b3 = 4'hF; v3 = 1'b1; ri3 = 1'b1;
        step();
        chk(y_o == 8'h0A, "basic_y_o", 32'(y_o), 32'h0A);
        chk(valid_o == 1'b1, "basic_valid_o", 32'(valid_o), 1);
        chk(y3 == 4'h0 && vo3 == 1'b1, "oor_select", {y3, 3'b0, vo3}, 32'h01);
        valid_i = 1'b0; v3 = 1'b0;
        step();
        chk(valid_o == 1'b0, "basic_drain", 32'(valid_o), 0);

        // Backpressure into the skid entry.
        ready_i = 1'b0; valid_i = 1'b1; s_i = 2'd0; b_i = 8'hFF;
        step();
        s_i = 2'd3;
        step();
        chk(ready_o == 1'b0 && y_o == 8'h55, "skid_full", {y_o, 7'b0, ready_o}, 32'h5500);
        s_i = 2'd2;
        step();
        chk(y_o == 8'h55, "skid_hold", 32'(y_o), 32'h55);
        valid_i = 1'b0; ready_i = 1'b1;
        step();
        chk(y_o == 8'hF0, "skid_second", 32'(y_o), 32'hF0);
        step();
        chk(ready_o == 1'b1 && valid_o == 1'b0, "skid_empty", {ready_o, valid_o}, 32'h2);

        // Streaming at full rate.
        for (int k = 0; k < 16; k++) begin
            valid_i = 1'b1; ready_i = 1'b1; s_i = 2'(k); b_i = 8'($urandom);
            step();
        end
        valid_i = 1'b0;
        step();

        // Mid-operation reset with main and skid both full.
        ready_i = 1'b0; valid_i = 1'b1; s_i = 2'd2; b_i = 8'hFF;
        step();
        s_i = 2'd1;
        step();
        valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        chk(valid_o == 1'b0 && ready_o == 1'b0, "mid_reset", {valid_o, ready_o}, 0);
        rst_i = 1'b0;
        #1;
        chk(valid_o == 1'b0 && ready_o == 1'b1, "post_reset", {valid_o, ready_o}, 32'h1);
        ready_i = 1'b1;
        step();
        step();

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 9) < 6);
            s_i = 2'($urandom);
            b_i = 8'($urandom);
            i_i = $urandom;
            rand3();
            rst_i = ($urandom_range(0, 99) == 0);
            step();
        end
        rst_i = 1'b0; valid_i = 1'b0; v3 = 1'b0; ready_i = 1'b1; ri3 = 1'b1;
        step();
        step();
        step();
        chk(q.size() == 0, "final_drain", q.size(), 0);
        chk(q3.size() == 0, "final_drain3", q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muxn_and_reg.md
Name: muxn_and_reg

Overview:
- Parametrised, registered successor of the two-input mux-then-AND merge cell.
- Selects one of NUM_IN data channels of WIDTH bits, ANDs the result bitwise with a gate vector, and registers it in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Used in pipelined datapaths built from discrete logic, where the mux/AND path must be cut by a register without losing throughput under backpressure.

Parameters:
- WIDTH, 1, data/gate width in bits (>=1).
- NUM_IN, 2, number of selectable input channels (>=2).
- SEL_W, derived as clog2(NUM_IN), select width; not overridable.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- i_i  input  NUM_IN*WIDTH  input channels; channel k occupies bits [k*WIDTH +: WIDTH].
- s_i  input  SEL_W  channel select, sampled with valid_i.
- b_i  input  WIDTH  AND gate vector, sampled with valid_i.
- valid_i  input  1  upstream data valid.
- ready_o  output  1  block can accept a transfer.
- y_o  output  WIDTH  registered result.
- valid_o  output  1  y_o valid.
- ready_i  input  1  downstream accepts y_o.

Behaviour:
- Combinational result: r = i_i[s_i*WIDTH +: WIDTH] & b_i.
- If s_i >= NUM_IN (non-power-of-2 NUM_IN), then r = 0; the transfer is still accepted normally.
- Input handshake: a transfer occurs on a rising edge with valid_i && ready_o.
- Output handshake: a transfer occurs on a rising edge with valid_o && ready_i.
- State is two entries:
  - main (drives y_o/valid_o);
  - skid (holds one overflow result).
- ready_o = !rst_i && !skid_valid. It is combinational from reset and skid state only, never from ready_i.
- Latency: an accepted input appears on y_o with valid_o=1 on the cycle after acceptance, provided main was empty or drained in the same cycle.
- Per-edge update, when not in reset:
  - Main empty, or main drained this cycle:
    - if skid holds data, skid moves to main and the new accept (if any) goes to skid;
    - else the accept (if any) goes to main;
    - if there is no data at all, main becomes invalid.
  - Main held (valid_o && !ready_i) and accept: result goes to skid; ready_o drops next cycle.
  - Main held, no accept: no change.
- Ordering is strictly FIFO; no transfer is dropped or duplicated.
- Full throughput: one transfer per cycle sustained when ready_i=1.
- Simultaneous accept and drain with skid empty: main is replaced by the new result, and valid_o stays 1.
- Stall: y_o and valid_o are stable while valid_o && !ready_i.
- Reset values (edge with rst_i=1):
  - valid_o=0, y_o=0, skid_valid=0, skid data=0;
  - ready_o reads 0 while rst_i=1 and 1 on the first cycle after deassertion.
- Reset mid-operation: all buffered data is discarded. No output transfer is signalled on the reset edge, regardless of ready_i.
- Data/select/gate are don't-care when valid_i=0. The X-free output rule holds: y_o only changes on an accept or drain.

Test Plan:
- Reset, then idle: rst_i=1 for 2 cycles -> y_o=0, valid_o=0, ready_o=0; after release -> ready_o=1, valid_o=0.
- Basic select/gate: WIDTH=8, NUM_IN=4, i_i={8'hF0,8'h3C,8'hAA,8'h55}, s_i=1, b_i=8'h0F, valid_i=1 for 1 cycle, ready_i=1 -> next cycle y_o=8'h0A, valid_o=1; following cycle valid_o=0.
- Backpressure/skid: ready_i=0; send s_i=0,b_i=FF then s_i=3,b_i=FF on consecutive cycles -> y_o=8'h55 held, ready_o=0 after second accept; third valid_i not accepted. Raise ready_i -> outputs 8'h55 then 8'hF0 in order, ready_o returns to 1.
- Streaming: valid_i=1, ready_i=1 for 16 cycles with s_i cycling 0..3 -> 16 outputs in order, one per cycle, ready_o constantly 1.
- Out-of-range select: NUM_IN=3, WIDTH=4, s_i=3, b_i=4'hF -> accepted, y_o=4'h0, valid_o=1.
- Reset mid-operation: with main and skid both full and ready_i=0, pulse rst_i for 1 cycle -> valid_o=0 and ready_o=0 during reset; after it, valid_o=0 and ready_o=1; no stale data is emitted when ready_i is later raised.
